// File: rtl/p4_router_pkg.sv
// Shared types and helpers for the p4_router ingress datapath.
// Holds the policer token type and the tkeep byte counter.
package p4_router_pkg;

    localparam int POLICER_TOKEN_WIDTH = 24;
    localparam int KEEP_MAX            = 128;

    typedef logic signed [POLICER_TOKEN_WIDTH-1:0] policer_token_t;

    // Number of valid bytes in a beat; callers zero-extend tkeep to KEEP_MAX.
    function automatic logic [7:0] keep_popcount(input logic [KEEP_MAX-1:0] keep);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            n = n + 8'(keep[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/AXIS_int.sv
// AXI-Stream bundle used on the converged ingress bus.
// Master drives payload and tvalid, Slave drives tready.
interface AXIS_int #(
    parameter int DATA_BYTES = 64,
    parameter int USER_W     = 8
);
    logic                    tvalid;
    logic                    tready;
    logic [DATA_BYTES*8-1:0] tdata;
    logic [DATA_BYTES-1:0]   tkeep;
    logic                    tlast;
    logic [USER_W-1:0]       tuser;

    modport Master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
    modport Slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/p4_router_token_bucket.sv
// One signed token bucket: refill with ceiling, byte debit with floor.
// A disabled bucket is parked at its burst size.
module p4_router_token_bucket #(
    parameter int TOKEN_WIDTH = 24,
    parameter int BYTES_W     = 7
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   refill_tick,
    input  logic [TOKEN_WIDTH-2:0] rate,
    input  logic [TOKEN_WIDTH-2:0] burst,
    input  logic                   debit_valid,
    input  logic [BYTES_W-1:0]     debit_bytes,
    input  logic                   enable,
    output logic                   negative
);
    localparam logic signed [TOKEN_WIDTH:0] FLOOR = {2'b11, {(TOKEN_WIDTH-1){1'b0}}};

    logic signed [TOKEN_WIDTH-1:0] bucket_q, bucket_d;
    logic signed [TOKEN_WIDTH:0]   sum, burst_x;

    // Refill and debit combine in one extra bit so the clamps see the true value.
    always_comb begin
        burst_x = {2'b00, burst};
        sum     = {bucket_q[TOKEN_WIDTH-1], bucket_q};
        if (refill_tick) begin
            sum = sum + {2'b00, rate};
        end
        if (debit_valid) begin
            sum = sum - {{(TOKEN_WIDTH+1-BYTES_W){1'b0}}, debit_bytes};
        end
        if (refill_tick && (sum > burst_x)) begin
            sum = burst_x;
        end
        if (sum < FLOOR) begin
            sum = FLOOR;
        end
        bucket_d = enable ? sum[TOKEN_WIDTH-1:0] : {1'b0, burst};
    end

    // Bucket state; empties on reset.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            bucket_q <= '0;
        end else begin
            bucket_q <= bucket_d;
        end
    end

    assign negative = bucket_q[TOKEN_WIDTH-1];

endmodule

// File: rtl/p4_router_ing_policer.sv
// Per-port token-bucket policer on the ingress bus, one register slice deep.
// Whole packets are forwarded or dropped on the bucket sign seen at SOP.
// Optional drop statistics: define P4_ROUTER_ING_POLICER_STATS_EN.
module p4_router_ing_policer
    import p4_router_pkg::*;
#(
    parameter int NUM_ING_PHYS_PORTS = 4,
    parameter int TOKEN_WIDTH        = POLICER_TOKEN_WIDTH,
    parameter int REFILL_PERIOD      = 256,
    parameter int DATA_BYTES         = 64,
    parameter int USER_W             = 8
) (
    input  logic                                          clk,
    input  logic                                          aresetn,
    AXIS_int.Slave                                        ing_bus_in,
    AXIS_int.Master                                       ing_bus_out,
    input  logic [NUM_ING_PHYS_PORTS-1:0]                 policer_enable,
    input  logic [NUM_ING_PHYS_PORTS-1:0][TOKEN_WIDTH-2:0] refill_rate,
    input  logic [NUM_ING_PHYS_PORTS-1:0][TOKEN_WIDTH-2:0] burst_size,
`ifdef P4_ROUTER_ING_POLICER_STATS_EN
    input  logic [NUM_ING_PHYS_PORTS-1:0]                 stats_clear,
    output logic [NUM_ING_PHYS_PORTS-1:0][31:0]           drop_pkt_cnt,
    output logic [NUM_ING_PHYS_PORTS-1:0][31:0]           drop_byte_cnt,
`endif
    output logic [NUM_ING_PHYS_PORTS-1:0]                 pkt_drop_pulse
);
    localparam int NP        = NUM_ING_PHYS_PORTS;
    localparam int PORT_W    = (NP > 1) ? $clog2(NP) : 1;
    localparam int PORT_SPAN = 1 << PORT_W;
    localparam int BYTES_W   = $clog2(DATA_BYTES + 1);
    localparam int CNT_W     = (REFILL_PERIOD > 1) ? $clog2(REFILL_PERIOD) : 1;

    logic [CNT_W-1:0]        refill_cnt_q, refill_cnt_d;
    logic                    refill_tick;
    logic                    in_pkt_q, drop_cur_q, port_ok_q, out_tvalid_q;
    logic [PORT_W-1:0]       port_q, in_port, cur_port;
    logic                    cur_ok, cur_drop;
    logic                    in_tready, accept, sop, fwd;
    logic [BYTES_W-1:0]      beat_bytes;
    logic [NP-1:0]           bucket_neg, debit_valid, drop_pulse_d, pkt_drop_pulse_q;
    logic [PORT_SPAN-1:0]    neg_ext, en_ext;
    logic [DATA_BYTES*8-1:0] out_tdata_q;
    logic [DATA_BYTES-1:0]   out_tkeep_q;
    logic                    out_tlast_q;
    logic [USER_W-1:0]       out_tuser_q;

    genvar gi;

    // Handshake, SOP detection and the drop decision (fresh at SOP, latched after).
    always_comb begin
        in_tready    = !out_tvalid_q || ing_bus_out.tready;
        accept       = ing_bus_in.tvalid && in_tready;
        sop          = accept && !in_pkt_q;
        in_port      = ing_bus_in.tuser[PORT_W-1:0];
        beat_bytes   = BYTES_W'(keep_popcount(KEEP_MAX'(ing_bus_in.tkeep)));
        refill_tick  = (refill_cnt_q == CNT_W'(REFILL_PERIOD - 1));
        refill_cnt_d = refill_tick ? '0 : refill_cnt_q + 1'b1;
        if (!in_pkt_q) begin
            cur_port = in_port;
            cur_ok   = int'(in_port) < NP;
            cur_drop = cur_ok && en_ext[in_port] && neg_ext[in_port];
        end else begin
            cur_port = port_q;
            cur_ok   = port_ok_q;
            cur_drop = drop_cur_q;
        end
        fwd = accept && !cur_drop;
        for (int p = 0; p < NP; p++) begin
            debit_valid[p]  = fwd && cur_ok && (int'(cur_port) == p);
            drop_pulse_d[p] = sop && cur_drop && (int'(cur_port) == p);
        end
    end

    // Pad per-port flags to the full index range so out-of-range ports read as 0.
    for (gi = 0; gi < PORT_SPAN; gi++) begin : g_ext
        if (gi < NP) begin : g_real
            assign neg_ext[gi] = bucket_neg[gi];
            assign en_ext[gi]  = policer_enable[gi];
        end else begin : g_pad
            assign neg_ext[gi] = 1'b0;
            assign en_ext[gi]  = 1'b0;
        end
    end

    for (gi = 0; gi < NP; gi++) begin : g_port
        p4_router_token_bucket #(
            .TOKEN_WIDTH (TOKEN_WIDTH),
            .BYTES_W     (BYTES_W)
        ) u_bucket (
            .clk         (clk),
            .aresetn     (aresetn),
            .refill_tick (refill_tick),
            .rate        (refill_rate[gi]),
            .burst       (burst_size[gi]),
            .debit_valid (debit_valid[gi]),
            .debit_bytes (beat_bytes),
            .enable      (policer_enable[gi]),
            .negative    (bucket_neg[gi])
        );
    end

    // Refill timer, packet state and output-slice valid.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            refill_cnt_q     <= '0;
            in_pkt_q         <= 1'b0;
            drop_cur_q       <= 1'b0;
            port_q           <= '0;
            port_ok_q        <= 1'b0;
            out_tvalid_q     <= 1'b0;
            pkt_drop_pulse_q <= '0;
        end else begin
            refill_cnt_q     <= refill_cnt_d;
            pkt_drop_pulse_q <= drop_pulse_d;
            if (accept) begin
                in_pkt_q   <= !ing_bus_in.tlast;
                drop_cur_q <= cur_drop;
                port_q     <= cur_port;
                port_ok_q  <= cur_ok;
            end
            if (in_tready) begin
                out_tvalid_q <= fwd;
            end
        end
    end

    // Output-slice payload; only qualified by tvalid, so no reset needed.
    always_ff @(posedge clk) begin
        if (in_tready && fwd) begin
            out_tdata_q <= ing_bus_in.tdata;
            out_tkeep_q <= ing_bus_in.tkeep;
            out_tlast_q <= ing_bus_in.tlast;
            out_tuser_q <= ing_bus_in.tuser;
        end
    end

    assign ing_bus_in.tready  = in_tready;
    assign ing_bus_out.tvalid = out_tvalid_q;
    assign ing_bus_out.tdata  = out_tdata_q;
    assign ing_bus_out.tkeep  = out_tkeep_q;
    assign ing_bus_out.tlast  = out_tlast_q;
    assign ing_bus_out.tuser  = out_tuser_q;
    assign pkt_drop_pulse     = pkt_drop_pulse_q;

`ifdef P4_ROUTER_ING_POLICER_STATS_EN
    for (gi = 0; gi < NP; gi++) begin : g_stats
        logic [31:0] pkt_cnt_q, byte_cnt_q;
        logic [32:0] byte_sum;
        logic        drop_beat;

        assign drop_beat = accept && cur_drop && (int'(cur_port) == gi);
        assign byte_sum  = {1'b0, byte_cnt_q} + 33'(beat_bytes);

        // Saturating drop counters; a clear beats a same-cycle increment.
        always_ff @(posedge clk or negedge aresetn) begin
            if (!aresetn) begin
                pkt_cnt_q  <= '0;
                byte_cnt_q <= '0;
            end else if (stats_clear[gi]) begin
                pkt_cnt_q  <= '0;
                byte_cnt_q <= '0;
            end else begin
                if (drop_pulse_d[gi] && (pkt_cnt_q != '1)) begin
                    pkt_cnt_q <= pkt_cnt_q + 1'b1;
                end
                if (drop_beat) begin
                    byte_cnt_q <= byte_sum[32] ? '1 : byte_sum[31:0];
                end
            end
        end

        assign drop_pkt_cnt[gi]  = pkt_cnt_q;
        assign drop_byte_cnt[gi] = byte_cnt_q;
    end
`endif

endmodule

// File: tb/tb_p4_router_ing_policer.sv
// Directed bench for the ingress policer: refill, debit, drop, backpressure,
// port isolation and mid-packet reset, with hand-computed expectations.
module tb_p4_router_ing_policer;
    import p4_router_pkg::*;

    localparam int NP = 4;
    localparam int TW = 24;
    localparam int RP = 4;
    localparam int DB = 64;
    localparam int UW = 8;

    logic                      clk = 1'b0;
    logic                      aresetn = 1'b0;
    logic [NP-1:0]             policer_enable;
    logic [NP-1:0][TW-2:0]     refill_rate;
    logic [NP-1:0][TW-2:0]     burst_size;
    logic [NP-1:0]             pkt_drop_pulse;

    AXIS_int #(.DATA_BYTES(DB), .USER_W(UW)) in_if ();
    AXIS_int #(.DATA_BYTES(DB), .USER_W(UW)) out_if ();

    p4_router_ing_policer #(
        .NUM_ING_PHYS_PORTS (NP),
        .TOKEN_WIDTH        (TW),
        .REFILL_PERIOD      (RP),
        .DATA_BYTES         (DB),
        .USER_W             (UW)
    ) dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .ing_bus_in     (in_if),
        .ing_bus_out    (out_if),
        .policer_enable (policer_enable),
        .refill_rate    (refill_rate),
        .burst_size     (burst_size),
        .pkt_drop_pulse (pkt_drop_pulse)
    );

    always #5 clk = ~clk;

    policer_token_t bk0, bk1, bk2, bk3;
    assign bk0 = dut.g_port[0].u_bucket.bucket_q;
    assign bk1 = dut.g_port[1].u_bucket.bucket_q;
    assign bk2 = dut.g_port[2].u_bucket.bucket_q;
    assign bk3 = dut.g_port[3].u_bucket.bucket_q;

    int tests_run    = 0;
    int tests_failed = 0;
    int next_seq     = 0;
    int phase        = 0;
    bit bp_mode      = 1'b0;
    bit rule_on      = 1'b0;
    int rule_viol    = 0;
    int drop_cnt [NP];
    int out_seq  [$];
    int out_bytes[$];
    int out_last [$];
    int out_user [$];

    task automatic check(input string tag, input longint got, input longint exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok %s = %0d", tag, got);
        end
    endtask

    // Bench copy of the refill phase: number of edges since reset, mod RP.
    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) phase <= 0;
        else          phase <= (phase == RP - 1) ? 0 : phase + 1;
    end

    // Downstream ready: steady 1, or toggling 1010.. in backpressure mode.
    always @(posedge clk) begin
        #1;
        if (bp_mode) out_if.tready = ~out_if.tready;
        else         out_if.tready = 1'b1;
    end

    // Output beats, drop pulses and the slice ready rule, sampled mid-cycle.
    always @(negedge clk) begin
        if (aresetn && out_if.tvalid && out_if.tready) begin
            out_seq.push_back(int'(out_if.tdata[31:0]));
            out_bytes.push_back($countones(out_if.tkeep));
            out_last.push_back(int'(out_if.tlast));
            out_user.push_back(int'(out_if.tuser));
        end
        for (int p = 0; p < NP; p++) begin
            if (pkt_drop_pulse[p]) drop_cnt[p]++;
        end
        if (rule_on && (in_if.tready !== (!out_if.tvalid || out_if.tready))) rule_viol++;
    end

    // Drive one beat (caller is between negedge and posedge); returns after acceptance edge.
    task automatic send_beat(input int port, input int nbytes, input bit last);
        bit acc;
        bit hs;
        in_if.tvalid     = 1'b1;
        in_if.tdata      = '0;
        in_if.tdata[31:0] = 32'(next_seq);
        in_if.tkeep      = (nbytes >= DB) ? '1 : ((64'd1 << nbytes) - 64'd1);
        in_if.tlast      = last;
        in_if.tuser      = UW'(port);
        next_seq++;
        acc = 1'b0;
        for (int w = 0; w < 64 && !acc; w++) begin
            #1;
            hs = in_if.tready;
            @(posedge clk);
            if (hs) acc = 1'b1;
            else    @(negedge clk);
        end
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic send_pkt(input int port, input int nbytes);
        int rem;
        rem = nbytes;
        while (rem > 0) begin
            @(negedge clk);
            send_beat(port, (rem > DB) ? DB : rem, rem <= DB);
            rem -= DB;
        end
        @(negedge clk);
        in_if.tvalid = 1'b0;
        $display("[TB] sent pkt port %0d bytes %0d", port, nbytes);
    endtask

    // Compare n output beats from index idx against seq s0.., port, byte total and tlast.
    task automatic check_beats(input string tag, input int idx, input int s0, input int n,
                               input int port, input int bytes);
        int bad;
        int sum;
        bad = 0;
        sum = 0;
        check({tag, "_count"}, out_seq.size() - idx, n);
        for (int i = 0; i < n; i++) begin
            if (idx + i >= out_seq.size()) begin
                bad++;
            end else begin
                if (out_seq[idx+i] != s0 + i) bad++;
                if (out_user[idx+i] != port) bad++;
                if (out_last[idx+i] != int'(i == n - 1)) bad++;
                sum += out_bytes[idx+i];
            end
        end
        check({tag, "_order"}, bad, 0);
        check({tag, "_bytes"}, sum, bytes);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int s0;
        int d0;
        for (int p = 0; p < NP; p++) drop_cnt[p] = 0;
        in_if.tvalid   = 1'b0;
        in_if.tdata    = '0;
        in_if.tkeep    = '0;
        in_if.tlast    = 1'b0;
        in_if.tuser    = '0;
        policer_enable = 4'b1000;
        refill_rate    = '0;
        burst_size     = '0;
        refill_rate[3] = 23'd100;
        burst_size[3]  = 23'd250;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_tvalid", out_if.tvalid, 0);
        check("rst_in_tready", in_if.tready, 1);
        check("rst_drop_pulse", pkt_drop_pulse, 0);
        check("rst_bucket0", bk0, 0);
        check("rst_bucket3", bk3, 0);
        aresetn = 1'b1;

        // Refill: RP=4, rate 100, burst 250 -> 100, 200, 250
        repeat (4) @(posedge clk);
        #1 check("t2_refill1", bk3, 100);
        repeat (4) @(posedge clk);
        #1 check("t2_refill2", bk3, 200);
        repeat (4) @(posedge clk);
        #1 check("t2_refill3_clamp", bk3, 250);

        // Port 0: preload to 1000 by parking, then 1500 B forwarded, 64 B dropped
        @(negedge clk);
        burst_size[0] = 23'd1000;
        repeat (2) @(negedge clk);
        check("t1_preload", bk0, 1000);
        policer_enable[0] = 1'b1;
        idx = out_seq.size();
        s0  = next_seq;
        send_pkt(0, 1500);
        repeat (4) @(negedge clk);
        check_beats("t1_pkt1", idx, s0, 24, 0, 1500);
        check("t1_bucket_deficit", bk0, -500);
        idx = out_seq.size();
        send_pkt(0, 64);
        repeat (4) @(negedge clk);
        check("t1_pkt2_out_beats", out_seq.size() - idx, 0);
        check("t1_drop_pulses", drop_cnt[0], 1);
        check("t1_bucket_after_drop", bk0, -500);

        // Same-cycle refill and debit: 50 + 100 - 64 = 86
        @(negedge clk);
        policer_enable[2] = 1'b0;
        burst_size[2]     = 23'd50;
        refill_rate[2]    = 23'd100;
        repeat (2) @(negedge clk);
        while (phase != 2) @(negedge clk);
        check("t3_start", bk2, 50);
        policer_enable[2] = 1'b1;
        burst_size[2]     = 23'd1000;
        @(negedge clk);
        idx = out_seq.size();
        s0  = next_seq;
        send_beat(2, 64, 1'b1);
        #1 check("t3_refill_and_debit", bk2, 86);
        @(negedge clk);
        in_if.tvalid = 1'b0;
        repeat (3) @(negedge clk);
        check_beats("t3_beat", idx, s0, 1, 2, 64);

        // Backpressure 1010 on a 3-beat bypassed packet
        rule_viol = 0;
        rule_on   = 1'b1;
        bp_mode   = 1'b1;
        idx = out_seq.size();
        s0  = next_seq;
        send_pkt(1, 3 * DB);
        repeat (8) @(negedge clk);
        bp_mode = 1'b0;
        repeat (2) @(negedge clk);
        rule_on = 1'b0;
        check_beats("t4_bp", idx, s0, 3, 1, 192);
        check("t4_tready_rule_viol", rule_viol, 0);

        // Isolation: port 1 bypassed, port 2 enabled at -1
        @(negedge clk);
        policer_enable[2] = 1'b0;
        burst_size[2]     = '0;
        refill_rate[2]    = '0;
        repeat (2) @(negedge clk);
        policer_enable[2] = 1'b1;
        send_pkt(2, 1);
        repeat (2) @(negedge clk);
        check("t5_bucket2_neg", bk2, -1);
        idx = out_seq.size();
        d0  = drop_cnt[2];
        s0  = next_seq;
        send_pkt(1, 100);
        send_pkt(2, 100);
        send_pkt(1, 10);
        send_pkt(2, 10);
        repeat (4) @(negedge clk);
        check("t5_port1_beats", out_seq.size() - idx, 3);
        check("t5_port2_drops", drop_cnt[2] - d0, 2);
        check("t5_port1_drops", drop_cnt[1], 0);
        check("t5_bucket2_kept", bk2, -1);
        if (out_seq.size() - idx == 3) begin
            check("t5_third_beat_seq", out_seq[idx+2], s0 + 4);
        end

        // Reset mid-packet on enabled port 3
        @(negedge clk);
        send_beat(3, 64, 1'b0);
        #1 check("t6_inflight_tvalid", out_if.tvalid, 1);
        in_if.tvalid = 1'b0;
        #1 aresetn = 1'b0;
        #1 check("t6_rst_out_tvalid", out_if.tvalid, 0);
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        #1;
        check("t6_bucket0", bk0, 0);
        check("t6_bucket1", bk1, 0);
        check("t6_bucket2", bk2, 0);
        check("t6_bucket3", bk3, 0);
        idx = out_seq.size();
        d0  = drop_cnt[3];
        s0  = next_seq;
        send_pkt(3, 40);
        repeat (4) @(negedge clk);
        check_beats("t6_new_sop", idx, s0, 1, 3, 40);
        check("t6_no_drop", drop_cnt[3] - d0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
